rggen_adapter_sliced: RTL and testbench
=======================================

// Module: rggen_adapter_sliced
// PURPOSE
//  Bus-to-register-file adapter; successor of the common adapter. Fans one rggen_bus_if
//  request out to REGISTERS rggen_register_if hosts and muxes their responses back.
//  Adds optional request/response register slices for timing closure and a
//  per-access watchdog that closes hung accesses with an error.
//  Sits between any protocol front-end (APB/AXI-lite/Avalon adapters) and the register blocks.
// PARAMETERS
//  BUS_WIDTH          32   data width of bus_if and register_if
//  REGISTERS          1    number of register_if hosts (>=1)
//  ERROR_STATUS       0    1: unmapped access returns RGGEN_SLAVE_ERROR; 0: RGGEN_OKAY
//  DEFAULT_READ_DATA  '0   read_data for unmapped or timed-out accesses
//  REQUEST_SLICE      0    1: register address/write/write_data/strobe before issue (+1 cycle)
//  RESPONSE_SLICE     0    1: register ready/status/read_data before bus return (+1 cycle)
//  TIMEOUT_CYCLES     256  watchdog limit in cycles (>=1); used only with RGGEN_ADAPTER_TIMEOUT_EN
// PORTS
//  i_clk        in     1          clock; all state updates on rising edge
//  i_rst        in     1          reset, synchronous, active-high
//  bus_if       slave  interface  rggen_bus_if: valid/address/write/write_data/strobe in;
//                                 ready/status/read_data out
//  register_if  host   [REGISTERS] rggen_register_if: valid/address/write/write_data/strobe out;
//                                 ready/active/status/read_data in
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state=IDLE, slice regs and watchdog counter cleared to 0.
//   While i_rst=1: bus_if.ready=0, all register_if[*].valid=0.
//  FSM states: IDLE, ISSUE (REQUEST_SLICE=1 only), WAIT, RESP (RESPONSE_SLICE=1 only).
//  hit = |register_if[*].ready | (~|register_if[*].active); the default responder is hit
//   when no register claims the address. Checked only in the issue cycle and in WAIT.
//  IDLE, bus_if.valid=1:
//   REQUEST_SLICE=0: register_if[*].valid=1 this cycle, request fields from bus_if directly.
//   REQUEST_SLICE=1: capture request fields, go ISSUE; register_if.valid stays 0.
//  Issue cycle (IDLE w/o slice, or ISSUE): register_if[*].valid=1 for exactly this cycle.
//   hit: respond (see below). No hit: go WAIT.
//  WAIT: register_if.valid=0, request fields held stable. hit -> respond.
//  Respond:
//   RESPONSE_SLICE=0: bus_if.ready=1 the same cycle; status/read_data one-hot muxed
//    from the hit source; next state IDLE.
//   RESPONSE_SLICE=1: capture status/read_data, go RESP.
//  RESP: bus_if.ready=1 for one cycle from captured values; next state IDLE.
//  Latency from bus_if.valid to bus_if.ready with immediate register ready:
//   0 cycles (no slices), +1 per enabled slice; max 2.
//  bus_if.ready is high for exactly one cycle per access. The next access may issue
//   in the cycle after ready.
//  Responses: multiple simultaneous ready is illegal and gives the OR of the hit sources.
//   Default responder status = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY,
//   read_data = DEFAULT_READ_DATA.
//  bus_if.valid dropped mid-access (protocol violation): access still completes with one
//   ready pulse. register_if.ready seen in IDLE is ignored.
//  Reset mid-access: abort, no ready pulse, IDLE on next cycle.
// CONFIGURATION
//  RGGEN_ADAPTER_TIMEOUT_EN defined: counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on issue
//   and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no hit, respond
//   RGGEN_SLAVE_ERROR with DEFAULT_READ_DATA via the normal respond path. A hit in the same
//   cycle wins over the timeout. A register ready arriving after the timeout is ignored.
//  Not defined: no counter, no timeout; WAIT holds until hit.
// TESTING
//  1 Slices 0, read hits reg0 with ready in issue cycle, read_data=32'hCAFE_0001
//    -> bus ready same cycle, OKAY, data CAFE_0001, register valid 1 cycle.
//  2 REQUEST_SLICE=1, RESPONSE_SLICE=1, write 32'h1234_5678 strobe 4'hF to reg1 with
//    immediate ready -> register valid at cycle 1, bus ready at cycle 2, OKAY.
//  3 Unmapped address (all active=0), ERROR_STATUS=1, DEFAULT_READ_DATA=32'hDEAD_BEEF
//    -> SLAVE_ERROR, data DEAD_BEEF.
//  4 reg0 delays ready 5 cycles -> WAIT 5 cycles, register valid 1 cycle only,
//    single bus ready pulse.
//  5 With RGGEN_ADAPTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, reg never readies -> SLAVE_ERROR
//    4 cycles after issue; next access completes normally.
//  6 i_rst=1 during WAIT -> no bus ready; IDLE next cycle; fresh access completes normally.

Source files
------------

// File: rtl/rggen_adapter_sliced.sv
// rggen_adapter_sliced
//   Bus-to-register-file adapter. Fans one bus request out to REGISTERS
//   register hosts and muxes their responses back. Optional request and
//   response register slices each add one cycle of latency. An optional
//   per-access watchdog closes hung accesses with a slave error.
//
//   Build option: define RGGEN_ADAPTER_TIMEOUT_EN to enable the watchdog.
//   Without it, an access waits in WAIT until some source responds.
//
// Ports (the bus and register interfaces are flattened into plain ports):
//   i_clk, i_rst              clock, synchronous active-high reset
//   bus_valid_i .. strobe_i   bus request (valid/address/write/write_data/strobe)
//   bus_ready_o .. read_data  bus response (ready/status/read_data)
//   register_valid_o          per-register request valid
//   register_address_o ..     request fields shared by all registers
//   register_ready_i          per-register ready
//   register_active_i         per-register address-claim flag
//   register_status_i         per-register status, packed [REGISTERS][2]
//   register_read_data_i      per-register read data, packed [REGISTERS][BUS_WIDTH]
module rggen_adapter_sliced #(
  parameter int unsigned          ADDRESS_WIDTH     = 16,
  parameter int unsigned          BUS_WIDTH         = 32,
  parameter int unsigned          REGISTERS         = 1,
  parameter bit                   ERROR_STATUS      = 1'b0,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0,
  parameter bit                   REQUEST_SLICE     = 1'b0,
  parameter bit                   RESPONSE_SLICE    = 1'b0,
  parameter int unsigned          TIMEOUT_CYCLES    = 256
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 bus_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]             bus_address_i,
  input  logic                                 bus_write_i,
  input  logic [BUS_WIDTH-1:0]                 bus_write_data_i,
  input  logic [BUS_WIDTH/8-1:0]               bus_strobe_i,
  output logic                                 bus_ready_o,
  output logic [1:0]                           bus_status_o,
  output logic [BUS_WIDTH-1:0]                 bus_read_data_o,
  output logic [REGISTERS-1:0]                 register_valid_o,
  output logic [ADDRESS_WIDTH-1:0]             register_address_o,
  output logic                                 register_write_o,
  output logic [BUS_WIDTH-1:0]                 register_write_data_o,
  output logic [BUS_WIDTH/8-1:0]               register_strobe_o,
  input  logic [REGISTERS-1:0]                 register_ready_i,
  input  logic [REGISTERS-1:0]                 register_active_i,
  input  logic [REGISTERS-1:0][1:0]            register_status_i,
  input  logic [REGISTERS-1:0][BUS_WIDTH-1:0]  register_read_data_i
);

  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
  localparam logic [1:0] DEFAULT_STATUS    = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                     write_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [BUS_WIDTH/8-1:0]   strobe_q;
  logic [1:0]               resp_status_q;
  logic [BUS_WIDTH-1:0]     resp_data_q;

  logic                     issue;
  logic                     check;
  logic                     hit;
  logic                     timeout;
  logic                     respond;
  logic [1:0]               mux_status;
  logic [BUS_WIDTH-1:0]     mux_data;
  state_e                   done_state;

  // Issue cycle: the IDLE cycle with valid when unsliced, otherwise ISSUE.
  always_comb begin
    issue = 1'b0;
    if (REQUEST_SLICE) begin
      issue = (state_q == ISSUE);
    end else begin
      issue = (state_q == IDLE) && bus_valid_i;
    end
  end

  // Ready is only looked at in the issue cycle and in WAIT, so a stray
  // register ready in IDLE/RESP has no effect.
  assign check      = issue || (state_q == WAIT);
  assign hit        = (|register_ready_i) || !(|register_active_i);
  assign respond    = check && (hit || timeout);
  assign done_state = RESPONSE_SLICE ? RESP : IDLE;

  // OR of all hit sources; a timeout (respond without hit) overrides.
  always_comb begin
    mux_status = '0;
    mux_data   = '0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      if (register_ready_i[i]) begin
        mux_status = mux_status | register_status_i[i];
        mux_data   = mux_data   | register_read_data_i[i];
      end
    end
    if (!(|register_active_i)) begin
      mux_status = mux_status | DEFAULT_STATUS;
      mux_data   = mux_data   | DEFAULT_READ_DATA;
    end
    if (!hit) begin
      mux_status = RGGEN_SLAVE_ERROR;
      mux_data   = DEFAULT_READ_DATA;
    end
  end

  // Unsliced issue drives bus fields straight through; every other cycle
  // presents the captured copy so fields stay stable through WAIT.
  always_comb begin
    if (!REQUEST_SLICE && (state_q == IDLE)) begin
      register_address_o    = bus_address_i;
      register_write_o      = bus_write_i;
      register_write_data_o = bus_write_data_i;
      register_strobe_o     = bus_strobe_i;
    end else begin
      register_address_o    = address_q;
      register_write_o      = write_q;
      register_write_data_o = write_data_q;
      register_strobe_o     = strobe_q;
    end
  end

  assign register_valid_o = {REGISTERS{issue && !i_rst}};

  always_comb begin
    if (RESPONSE_SLICE) begin
      bus_ready_o     = (state_q == RESP) && !i_rst;
      bus_status_o    = resp_status_q;
      bus_read_data_o = resp_data_q;
    end else begin
      bus_ready_o     = respond && !i_rst;
      bus_status_o    = mux_status;
      bus_read_data_o = mux_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      address_q     <= '0;
      write_q       <= 1'b0;
      write_data_q  <= '0;
      strobe_q      <= '0;
      resp_status_q <= '0;
      resp_data_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus_valid_i) begin
            address_q    <= bus_address_i;
            write_q      <= bus_write_i;
            write_data_q <= bus_write_data_i;
            strobe_q     <= bus_strobe_i;
            if (REQUEST_SLICE) begin
              state_q <= ISSUE;
            end else if (respond) begin
              state_q <= done_state;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        ISSUE, WAIT: begin
          state_q <= respond ? done_state : WAIT;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (RESPONSE_SLICE && respond) begin
        resp_status_q <= mux_status;
        resp_data_q   <= mux_data;
      end
    end
  end

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdog_q <= '0;
    end else if (issue) begin
      wdog_q <= '0;
    end else if (state_q == WAIT) begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  // Fires in the WAIT cycle where the count reaches TIMEOUT_CYCLES, i.e.
  // TIMEOUT_CYCLES cycles after issue; a hit in that cycle still wins.
  assign timeout = (state_q == WAIT) && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_cfg_unused;

  assign timeout_cfg_unused = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_rggen_adapter_sliced.sv
`timescale 1ns/1ps
module tb_rggen_adapter_sliced;

  localparam int AW = 16;
  localparam int BW = 32;
  localparam int SW = 4;
  localparam int R  = 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;

  // Instance 0: no slices, ERROR_STATUS=1, default data DEAD_BEEF, timeout 4.
  // Instance 1: both slices, ERROR_STATUS=0, timeout 16.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic                 bus_valid [2];
  logic [AW-1:0]        bus_addr  [2];
  logic                 bus_write [2];
  logic [BW-1:0]        bus_wdata [2];
  logic [SW-1:0]        bus_strb  [2];
  logic                 bus_ready [2];
  logic [1:0]           bus_status[2];
  logic [BW-1:0]        bus_rdata [2];
  logic [R-1:0]         reg_valid [2];
  logic [AW-1:0]        reg_addr  [2];
  logic                 reg_write [2];
  logic [BW-1:0]        reg_wdata [2];
  logic [SW-1:0]        reg_strb  [2];
  logic [R-1:0]         reg_ready [2];
  logic [R-1:0]         reg_active[2];
  logic [R-1:0][1:0]    reg_status[2];
  logic [R-1:0][BW-1:0] reg_rdata [2];

  // Register responder model controls and monitor state.
  int            m_tgt  [2];
  int            m_delay[2];  // 0: ready in issue cycle, -1: never
  logic          m_pend [2];
  int            m_cnt  [2];
  int            vcnt   [2];
  int            rcnt   [2];
  int            vcyc   [2];
  logic [AW-1:0] cap_addr [2];
  logic          cap_write[2];
  logic [BW-1:0] cap_wdata[2];
  logic [SW-1:0] cap_strb [2];

  typedef struct {
    logic [1:0]    status;
    logic [BW-1:0] data;
    int            lat;
  } exp_t;
  exp_t exp_q[$];

  rggen_adapter_sliced #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(R), .ERROR_STATUS(1'b1),
    .DEFAULT_READ_DATA(32'hDEAD_BEEF), .REQUEST_SLICE(1'b0), .RESPONSE_SLICE(1'b0),
    .TIMEOUT_CYCLES(4)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .bus_valid_i(bus_valid[0]), .bus_address_i(bus_addr[0]), .bus_write_i(bus_write[0]),
    .bus_write_data_i(bus_wdata[0]), .bus_strobe_i(bus_strb[0]),
    .bus_ready_o(bus_ready[0]), .bus_status_o(bus_status[0]), .bus_read_data_o(bus_rdata[0]),
    .register_valid_o(reg_valid[0]), .register_address_o(reg_addr[0]),
    .register_write_o(reg_write[0]), .register_write_data_o(reg_wdata[0]),
    .register_strobe_o(reg_strb[0]), .register_ready_i(reg_ready[0]),
    .register_active_i(reg_active[0]), .register_status_i(reg_status[0]),
    .register_read_data_i(reg_rdata[0])
  );

  rggen_adapter_sliced #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(R), .ERROR_STATUS(1'b0),
    .DEFAULT_READ_DATA(32'h0BAD_F00D), .REQUEST_SLICE(1'b1), .RESPONSE_SLICE(1'b1),
    .TIMEOUT_CYCLES(16)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .bus_valid_i(bus_valid[1]), .bus_address_i(bus_addr[1]), .bus_write_i(bus_write[1]),
    .bus_write_data_i(bus_wdata[1]), .bus_strobe_i(bus_strb[1]),
    .bus_ready_o(bus_ready[1]), .bus_status_o(bus_status[1]), .bus_read_data_o(bus_rdata[1]),
    .register_valid_o(reg_valid[1]), .register_address_o(reg_addr[1]),
    .register_write_o(reg_write[1]), .register_write_data_o(reg_wdata[1]),
    .register_strobe_o(reg_strb[1]), .register_ready_i(reg_ready[1]),
    .register_active_i(reg_active[1]), .register_status_i(reg_status[1]),
    .register_read_data_i(reg_rdata[1])
  );

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      reg_ready[g] = '0;
      for (int k = 0; k < R; k++) begin
        reg_ready[g][k] = reg_active[g][k] && (m_tgt[g] == k) &&
                          ((reg_valid[g][k] && (m_delay[g] == 0)) ||
                           (m_pend[g] && (m_cnt[g] == m_delay[g])));
      end
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_pend[g] <= 1'b0;
      end else if ((|reg_valid[g]) && (m_delay[g] != 0)) begin
        m_pend[g] <= 1'b1;
        m_cnt[g]  <= 1;
      end else if (m_pend[g]) begin
        if ((|reg_ready[g]) || bus_ready[g]) m_pend[g] <= 1'b0;
        else m_cnt[g] <= m_cnt[g] + 1;
      end
      if (|reg_valid[g]) begin
        vcnt[g]      <= vcnt[g] + 1;
        vcyc[g]      <= cyc;
        cap_addr[g]  <= reg_addr[g];
        cap_write[g] <= reg_write[g];
        cap_wdata[g] <= reg_wdata[g];
        cap_strb[g]  <= reg_strb[g];
      end
      if (bus_ready[g]) rcnt[g] <= rcnt[g] + 1;
    end
  end

  task automatic setup_regs(input int g, input logic [R-1:0] active, input int tgt, input int delay);
    reg_active[g] = active;
    m_tgt[g]      = tgt;
    m_delay[g]    = delay;
  endtask

  // Drives one access and waits (bounded) for the bus ready pulse.
  task automatic access(input int g, input logic wr, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wd, input logic [SW-1:0] st,
                        output bit got, output logic [1:0] status,
                        output logic [BW-1:0] rdata, output int lat, output int start);
    @(posedge clk); #1;
    bus_valid[g] = 1'b1;
    bus_write[g] = wr;
    bus_addr[g]  = addr;
    bus_wdata[g] = wd;
    bus_strb[g]  = st;
    start  = cyc;
    got    = 1'b0;
    lat    = 0;
    status = 'x;
    rdata  = 'x;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus_ready[g]) begin
        got    = 1'b1;
        status = bus_status[g];
        rdata  = bus_rdata[g];
      end else begin
        lat++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus_valid[g] = 1'b0;
  endtask

  task automatic test_reset;
    bus_valid[0] = 1'b1;
    bus_valid[1] = 1'b1;
    setup_regs(0, 2'b00, 0, 0);
    setup_regs(1, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (bus_ready[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", g, bus_ready[g]);
      end
      n_checks++;
      if (reg_valid[g] !== '0) begin
        n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 00", g, reg_valid[g]);
      end
    end
    @(posedge clk); #1;
    bus_valid[0] = 1'b0;
    bus_valid[1] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ((vcnt[0] + vcnt[1] + rcnt[0] + rcnt[1]) !== 0) begin
      n_fail++; $display("FAIL reset_pulses: got %0d pulses expected 0", vcnt[0] + vcnt[1] + rcnt[0] + rcnt[1]);
    end
  endtask

  task automatic test_single_read;
    bit got; logic [1:0] st; logic [BW-1:0] rd; int lat, start, v0; exp_t e;
    setup_regs(0, 2'b01, 0, 0);
    reg_status[0][0] = OKAY;
    reg_rdata[0][0]  = 32'hCAFE_0001;
    v0 = vcnt[0];
    exp_q.push_back('{OKAY, 32'hCAFE_0001, 0});
    access(0, 1'b0, 16'h0010, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL read_ready: no ready within budget"); end
    n_checks++; if (st !== e.status) begin n_fail++; $display("FAIL read_status: got %b expected %b", st, e.status); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL read_data: got %h expected %h", rd, e.data); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, e.lat); end
    n_checks++; if (vcnt[0] - v0 !== 1) begin n_fail++; $display("FAIL read_valid_cycles: got %0d expected 1", vcnt[0] - v0); end
    n_checks++; if (cap_addr[0] !== 16'h0010) begin n_fail++; $display("FAIL read_addr: got %h expected 0010", cap_addr[0]); end
  endtask

  task automatic test_sliced_write;
    bit got; logic [1:0] st; logic [BW-1:0] rd; int lat, start, r0; exp_t e;
    setup_regs(1, 2'b10, 1, 0);
    reg_status[1][1] = OKAY;
    reg_rdata[1][1]  = 32'h0000_0077;
    r0 = rcnt[1];
    exp_q.push_back('{OKAY, 32'h0000_0077, 2});
    access(1, 1'b1, 16'h0024, 32'h1234_5678, 4'hF, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL swr_ready: no ready within budget"); end
    n_checks++; if (st !== e.status) begin n_fail++; $display("FAIL swr_status: got %b expected %b", st, e.status); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL swr_latency: got %0d expected %0d", lat, e.lat); end
    n_checks++; if (vcyc[1] - start !== 1) begin n_fail++; $display("FAIL swr_valid_cycle: got %0d expected 1", vcyc[1] - start); end
    n_checks++; if (cap_wdata[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL swr_wdata: got %h expected 12345678", cap_wdata[1]); end
    n_checks++; if (cap_strb[1] !== 4'hF || cap_write[1] !== 1'b1) begin
      n_fail++; $display("FAIL swr_strobe_write: got %h/%b expected f/1", cap_strb[1], cap_write[1]);
    end
    n_checks++; if (rcnt[1] - r0 !== 1) begin n_fail++; $display("FAIL swr_ready_pulses: got %0d expected 1", rcnt[1] - r0); end
  endtask

  task automatic test_unmapped;
    bit got; logic [1:0] st; logic [BW-1:0] rd; int lat, start; exp_t e;
    setup_regs(0, 2'b00, 0, 0);
    exp_q.push_back('{SLVERR, 32'hDEAD_BEEF, 0});
    access(0, 1'b0, 16'h0FF0, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL unmapped_ready: no ready within budget"); end
    n_checks++; if (st !== e.status) begin n_fail++; $display("FAIL unmapped_status: got %b expected %b", st, e.status); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL unmapped_data: got %h expected %h", rd, e.data); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL unmapped_latency: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_wait_delay;
    bit got; logic [1:0] st; logic [BW-1:0] rd; int lat, start, v0, r0; exp_t e;
    setup_regs(1, 2'b01, 0, 5);
    reg_status[1][0] = EXOKAY;
    reg_rdata[1][0]  = 32'h0000_A5A5;
    v0 = vcnt[1]; r0 = rcnt[1];
    exp_q.push_back('{EXOKAY, 32'h0000_A5A5, 7});  // 1 request slice + 5 wait + 1 response slice
    access(1, 1'b0, 16'h0008, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL wait_ready: no ready within budget"); end
    n_checks++; if (st !== e.status) begin n_fail++; $display("FAIL wait_status: got %b expected %b", st, e.status); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL wait_data: got %h expected %h", rd, e.data); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL wait_latency: got %0d expected %0d", lat, e.lat); end
    n_checks++; if (vcnt[1] - v0 !== 1) begin n_fail++; $display("FAIL wait_valid_cycles: got %0d expected 1", vcnt[1] - v0); end
    n_checks++; if (rcnt[1] - r0 !== 1) begin n_fail++; $display("FAIL wait_ready_pulses: got %0d expected 1", rcnt[1] - r0); end
  endtask

  task automatic test_timeout;
    bit got; logic [1:0] st; logic [BW-1:0] rd; int lat, start; exp_t e;
    reg_status[0][0] = OKAY;
    reg_rdata[0][0]  = 32'h0000_1357;
`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    setup_regs(0, 2'b01, 0, -1);
    exp_q.push_back('{SLVERR, 32'hDEAD_BEEF, 4});
    access(0, 1'b0, 16'h0010, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL tmo_ready: no ready within budget"); end
    n_checks++; if (st !== e.status) begin n_fail++; $display("FAIL tmo_status: got %b expected %b", st, e.status); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL tmo_data: got %h expected %h", rd, e.data); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", lat, e.lat); end
    // Register ready in the same cycle as the timeout must win.
    setup_regs(0, 2'b01, 0, 4);
    exp_q.push_back('{OKAY, 32'h0000_1357, 4});
    access(0, 1'b0, 16'h0010, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (st !== e.status || rd !== e.data) begin
      n_fail++; $display("FAIL tmo_hit_wins: got %b/%h expected %b/%h", st, rd, e.status, e.data);
    end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL tmo_hit_latency: got %0d expected %0d", lat, e.lat); end
    setup_regs(0, 2'b01, 0, 0);
    exp_q.push_back('{OKAY, 32'h0000_1357, 0});
`else
    setup_regs(0, 2'b01, 0, 12);
    exp_q.push_back('{OKAY, 32'h0000_1357, 12});
`endif
    access(0, 1'b0, 16'h0010, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL tmo_next_ready: no ready within budget"); end
    n_checks++; if (st !== e.status || rd !== e.data) begin
      n_fail++; $display("FAIL tmo_next_resp: got %b/%h expected %b/%h", st, rd, e.status, e.data);
    end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL tmo_next_latency: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid_wait;
    bit got; logic [1:0] st; logic [BW-1:0] rd; int lat, start, r0; exp_t e;
    setup_regs(1, 2'b01, 0, -1);
    r0 = rcnt[1];
    @(posedge clk); #1;
    bus_valid[1] = 1'b1;
    bus_write[1] = 1'b0;
    bus_addr[1]  = 16'h0004;
    repeat (4) @(posedge clk);
    #1;
    bus_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_ready[1] !== 1'b0 || reg_valid[1] !== '0) begin
      n_fail++; $display("FAIL rstw_during: got ready=%b valid=%b expected 0/00", bus_ready[1], reg_valid[1]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_ready[1] !== 1'b0 || reg_valid[1] !== '0) begin
      n_fail++; $display("FAIL rstw_after: got ready=%b valid=%b expected 0/00", bus_ready[1], reg_valid[1]);
    end
    n_checks++; if (rcnt[1] - r0 !== 0) begin n_fail++; $display("FAIL rstw_no_ready: got %0d pulses expected 0", rcnt[1] - r0); end
    setup_regs(1, 2'b01, 0, 0);
    reg_status[1][0] = OKAY;
    reg_rdata[1][0]  = 32'h2468_ACE0;
    exp_q.push_back('{OKAY, 32'h2468_ACE0, 2});
    access(1, 1'b0, 16'h0004, '0, '0, got, st, rd, lat, start);
    e = exp_q.pop_front();
    n_checks++; if (!got) begin n_fail++; $display("FAIL rstw_fresh_ready: no ready within budget"); end
    n_checks++; if (st !== e.status || rd !== e.data) begin
      n_fail++; $display("FAIL rstw_fresh_resp: got %b/%h expected %b/%h", st, rd, e.status, e.data);
    end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL rstw_fresh_latency: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back;
    int v0, r0; exp_t e;
    setup_regs(0, 2'b10, 1, 0);
    reg_status[0][1] = OKAY;
    reg_rdata[0][1]  = 32'h5A5A_0002;
    v0 = vcnt[0]; r0 = rcnt[0];
    @(posedge clk); #1;
    bus_valid[0] = 1'b1;
    bus_write[0] = 1'b0;
    bus_addr[0]  = 16'h0040;
    exp_q.push_back('{OKAY, 32'h5A5A_0002, 0});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if (bus_ready[0] !== 1'b1 || bus_rdata[0] !== e.data) begin
      n_fail++; $display("FAIL b2b_first: got ready=%b data=%h expected 1/%h", bus_ready[0], bus_rdata[0], e.data);
    end
    @(posedge clk); #1;
    bus_write[0] = 1'b1;
    bus_addr[0]  = 16'h0044;
    bus_wdata[0] = 32'h1111_2222;
    bus_strb[0]  = 4'h3;
    exp_q.push_back('{OKAY, 32'h5A5A_0002, 0});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if (bus_ready[0] !== 1'b1 || bus_status[0] !== e.status) begin
      n_fail++; $display("FAIL b2b_second: got ready=%b status=%b expected 1/%b", bus_ready[0], bus_status[0], e.status);
    end
    @(posedge clk); #1;
    bus_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (vcnt[0] - v0 !== 2 || rcnt[0] - r0 !== 2) begin
      n_fail++; $display("FAIL b2b_pulses: got valid=%0d ready=%0d expected 2/2", vcnt[0] - v0, rcnt[0] - r0);
    end
    n_checks++; if (cap_wdata[0] !== 32'h1111_2222 || cap_addr[0] !== 16'h0044 || cap_strb[0] !== 4'h3) begin
      n_fail++; $display("FAIL b2b_fields: got %h/%h/%h expected 0044/11112222/3", cap_addr[0], cap_wdata[0], cap_strb[0]);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      bus_valid[g] = 1'b0; bus_addr[g] = '0; bus_write[g] = 1'b0;
      bus_wdata[g] = '0;   bus_strb[g] = '0;
      reg_active[g] = '0;  reg_status[g] = '0; reg_rdata[g] = '0;
      m_tgt[g] = 0; m_delay[g] = 0; m_cnt[g] = 0;
      vcnt[g] = 0;  rcnt[g] = 0;    vcyc[g] = 0;
    end
    test_reset();
    test_single_read();
    test_sliced_write();
    test_unmapped();
    test_wait_delay();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

endmodule
